// File: rtl/otter_branch_predictor_if.sv
// Fetch-side lookup, EX-side training and statistics signals of the OTTER
// branch target buffer, bundled so the predictor and its user share one bus.
interface otter_branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             lookup_en;
  logic [XLEN-1:0]  lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_next_pc;

  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_is_jump;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_mispredict;

  logic             inv;

  logic [CNT_W-1:0] stat_hits;
  logic [CNT_W-1:0] stat_mispred;

  // Pipeline side: drives fetch PC and resolved-branch training.
  modport master (
    output lookup_en, lookup_pc,
    output upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, upd_mispredict,
    output inv,
    input  pred_hit, pred_taken, pred_next_pc,
    input  stat_hits, stat_mispred
  );

  // Predictor side.
  modport slave (
    input  lookup_en, lookup_pc,
    input  upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, upd_mispredict,
    input  inv,
    output pred_hit, pred_taken, pred_next_pc,
    output stat_hits, stat_mispred
  );
endinterface

// File: rtl/otter_branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Looked up combinationally with the fetch PC, trained from EX,
// with saturating hit and mispredict statistics.
module otter_branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  otter_branch_predictor_if.slave bp
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  // Weakly not-taken after reset, weakly taken on a fresh branch allocation.
  localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT  = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(2 ** (CTR_BITS - 1));

  logic [ENTRIES-1:0]  r_valid;
  logic [TAGW-1:0]     r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr    [ENTRIES];

  logic [CNT_W-1:0]    r_hits;
  logic [CNT_W-1:0]    r_mispred;

  logic [IDX-1:0]      w_lidx;
  logic [TAGW-1:0]     w_ltag;
  logic                w_hit;
  logic                w_taken;

  logic [IDX-1:0]      w_uidx;
  logic [TAGW-1:0]     w_utag;
  logic                w_uhit;
  logic                w_upd_ok;
  logic                w_we_entry;
  logic                w_we_target;
  logic [CTR_BITS-1:0] w_ctr_cur;
  logic [CTR_BITS-1:0] w_ctr_next;

  logic                w_unused;

  assign w_lidx = bp.lookup_pc[IDX+1:2];
  assign w_ltag = bp.lookup_pc[XLEN-1:IDX+2];
  assign w_uidx = bp.upd_pc[IDX+1:2];
  assign w_utag = bp.upd_pc[XLEN-1:IDX+2];

  // PC bits [1:0] never select an entry or form part of the tag.
  assign w_unused = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0]};

  // Fetch-side lookup: reads state as of the last edge, so a same-cycle
  // update is only seen one cycle later. Forced to miss while in reset.
  always_comb begin
    w_hit   = ~i_rst & r_valid[w_lidx] & (r_tag[w_lidx] == w_ltag);
    w_taken = w_hit & r_ctr[w_lidx][CTR_BITS-1];
  end

  assign bp.pred_hit     = w_hit;
  assign bp.pred_taken   = w_taken;
  assign bp.pred_next_pc = w_taken ? r_target[w_lidx] : bp.lookup_pc + XLEN'(4);

  // Training decision: hits always retrain, misses allocate only when taken.
  always_comb begin
    w_uhit      = r_valid[w_uidx] & (r_tag[w_uidx] == w_utag);
    w_upd_ok    = bp.upd_valid & ~bp.inv & ~i_rst;
    w_we_entry  = w_upd_ok & (w_uhit | bp.upd_taken);
    w_we_target = w_upd_ok & (bp.upd_is_jump ? w_uhit | bp.upd_taken : bp.upd_taken);
    w_ctr_cur   = r_ctr[w_uidx];
    w_ctr_next  = w_ctr_cur;
    if (w_uhit) begin
      if (bp.upd_is_jump)
        w_ctr_next = CTR_MAX;
      else if (bp.upd_taken)
        w_ctr_next = (w_ctr_cur == CTR_MAX) ? CTR_MAX : w_ctr_cur + CTR_BITS'(1);
      else
        w_ctr_next = (w_ctr_cur == '0) ? '0 : w_ctr_cur - CTR_BITS'(1);
    end else begin
      w_ctr_next = bp.upd_is_jump ? CTR_MAX : CTR_ALLOC;
    end
  end

  // Valid bits and direction counters: reset clears, inv drops all entries.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++)
        r_ctr[i] <= CTR_INIT;
    end else if (bp.inv) begin
      r_valid <= '0;
    end else if (w_we_entry) begin
      r_valid[w_uidx] <= 1'b1;
      r_ctr[w_uidx]   <= w_ctr_next;
    end
  end

  // Tag and target storage needs no reset; it is only trusted when valid.
  always_ff @(posedge i_clk) begin
    if (w_we_entry)
      r_tag[w_uidx] <= w_utag;
    if (w_we_target)
      r_target[w_uidx] <= bp.upd_target;
  end

  // Saturating statistics, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hits    <= '0;
      r_mispred <= '0;
    end else begin
      if (bp.lookup_en && w_hit && (r_hits != '1))
        r_hits <= r_hits + CNT_W'(1);
      if (bp.upd_valid && bp.upd_mispredict && (r_mispred != '1))
        r_mispred <= r_mispred + CNT_W'(1);
    end
  end

  assign bp.stat_hits    = r_hits;
  assign bp.stat_mispred = r_mispred;

endmodule

// File: doc/otter_branch_predictor.md
Name: otter_branch_predictor

Overview:
- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters for the OTTER pipeline.
- Looked up combinationally with the fetch PC in IF, and supplies the predicted next PC to the PC mux.
- Trained from EX when a branch or jump resolves.
- Replaces the static "always npc" fetch policy. Adds configurable depth, counter width and saturating statistics counters.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, number of table entries; power of two, >= 2.
- CTR_BITS, 2, direction counter width; >= 1.
- CNT_W, 32, width of statistics counters.
- Derived: IDX = log2(ENTRIES); index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- lookup_en  in  1  fetch PC valid this cycle (qualifies stat_hits only).
- lookup_pc  in  XLEN  fetch PC.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  pred_hit & counter MSB set.
- pred_next_pc  out  XLEN  pred_taken ? stored target : lookup_pc+4.
- upd_valid  in  1  resolved control-flow instruction in EX.
- upd_pc  in  XLEN  PC of resolved instruction.
- upd_is_jump  in  1  1 = JAL/JALR (unconditional), 0 = conditional branch.
- upd_taken  in  1  actual direction.
- upd_target  in  XLEN  actual target.
- upd_mispredict  in  1  EX detected wrong prediction (statistics only).
- inv  in  1  invalidate all entries (e.g. fence/context change).
- stat_hits  out  CNT_W  lookups that hit.
- stat_mispred  out  CNT_W  reported mispredicts.

Behaviour:
- Reset: only one clock; reset is synchronous and active-high. With RST high at posedge:
  - all valid bits = 0;
  - all counters = CTR_INIT = 2^(CTR_BITS-1)-1 (weakly not-taken);
  - stat_hits = stat_mispred = 0;
  - any update or inv in that cycle is ignored.
- Outputs during and after reset: pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4.
- Lookup: purely combinational, zero latency. Reads state as of the last clock edge.
  - For a same-cycle update to the same index, the lookup sees the old contents; the update is visible the next cycle.
- Update on posedge with upd_valid & ~inv & ~RST, where hit means valid & tag(upd_pc) matches:
  - Hit, jump: counter = all-ones; target = upd_target.
  - Hit, branch taken: counter = min(ctr+1, max); target = upd_target.
  - Hit, branch not-taken: counter = max(ctr-1, 0); target unchanged; entry stays valid.
  - Miss, taken (branch or jump): allocate at index, overwriting any alias. Set valid=1, tag, target = upd_target. Counter = all-ones for a jump, CTR_INIT+1 for a branch (weakly taken; all-ones when CTR_BITS=1).
  - Miss, not-taken: no change.
- inv: all valid bits cleared at posedge; counters and targets are don't-care. inv wins over a simultaneous upd_valid.
- Statistics:
  - stat_hits += 1 when lookup_en & pred_hit.
  - stat_mispred += 1 when upd_valid & upd_mispredict.
  - Both saturate at all-ones (no wrap) and are cleared only by RST, not by inv.
- Arithmetic: lookup_pc+4 is modulo 2^XLEN; 0xFFFFFFFC+4 gives 0.
- Storage: the table may be flops or distributed RAM. One write per cycle; asynchronous read required.

Test Plan:
- Reset, then lookup_pc=0x100, lookup_en=1 -> pred_hit=0, pred_taken=0, pred_next_pc=0x104, stat_hits=0.
- Update pc=0x100, branch, taken, target=0x80. Next cycle lookup 0x100 -> hit=1, taken=1, next_pc=0x80 (ctr=2). Then update not-taken -> ctr=1, hit=1, taken=0, next_pc=0x104.
- Three more taken updates on 0x100 -> ctr saturates at 3. One not-taken -> ctr=2, still taken. Jump update on 0x300 -> ctr=3 immediately, next_pc=upd_target.
- Alias with ENTRIES=64: entry 0x100 valid; taken update pc=0x200 (same index 0, different tag), target=0x40 -> lookup 0x100 misses, next_pc=0x104; lookup 0x200 -> next_pc=0x40. Not-taken miss update at 0x400 -> 0x200 entry unchanged.
- Same-cycle lookup and update on 0x500 (first allocation) -> that cycle hit=0; next cycle hit=1. Assert inv together with upd_valid -> next cycle all lookups miss, stats unchanged.
- CNT_W=4: 20 updates with upd_mispredict=1 -> stat_mispred=15 (saturated). Assert RST mid-sequence with upd_valid=1 -> counters 0, table empty, update discarded.
